mem_access_unit: RTL
====================

# mem_access_unit

Initiator for the single-port word RAM's request/ready protocol. It accepts one load, store or atomic swap at a time from the CPU datapath and drives `read`/`write` with addresses and data toward the RAM. It waits for `rrdy`/`wrdy`, samples `exc`, and returns read data with a one-cycle `done` pulse and a fault code. It sits between the CPU32 execute stage and `ram`. A timeout guards against a RAM that never answers.

## Interface
- `TIMEOUT`, default 16: maximum cycles per access phase before a timeout fault; minimum 2.
- `MEM_SIZE`, default 1024: word count of the attached RAM. Used only when `ADDR_CHECK_EN` is defined.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `cpu_addr`  in  32  word address of the request.
- `cpu_wdata`  in  32  store data.
- `cpu_rd`  in  1  read request.
- `cpu_wr`  in  1  write request. `cpu_rd` and `cpu_wr` together request an atomic swap.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  32  read data. Valid while `done`=1 and held until the next acceptance.
- `fault`  out  2  result code, valid with `done`:
  - 00: ok
  - 01: read exc
  - 10: write exc
  - 11: timeout
- `r_addr`  out  32  RAM read address.
- `w_addr`  out  32  RAM write address.
- `w_line`  out  32  RAM write data.
- `r_line`  in  32  RAM read data. Valid only while `rrdy`=1; tri-stated otherwise.
- `read`  out  1  RAM read strobe.
- `write`  out  1  RAM write strobe.
- `rrdy`  in  1  RAM read-complete pulse.
- `wrdy`  in  1  RAM write-complete pulse.
- `exc`  in  1  RAM out-of-range flag. It is registered and stays set until the next successful RAM access.

## Operation
States: IDLE, RD, WR, DONE. All outputs are registered. `read` is high exactly while in RD; `write` is high exactly while in WR.

- **IDLE**
  - On `cpu_rd|cpu_wr`: capture `cpu_addr` into `r_addr` and `w_addr`, capture `cpu_wdata` into `w_line`, latch the op, and clear the phase counter.
  - Go to RD if `cpu_rd`=1, else go to WR.
  - `rrdy`, `wrdy` and `exc` are ignored in IDLE.
- **RD** (checks in priority order)
  - `rrdy`=1: latch `r_line` into `cpu_rdata`. Go to WR if the op is a swap, else go to DONE with `fault`=00.
  - `exc`=1 and counter≠0: set `fault`=01 and go to DONE. The write half of a swap is skipped.
  - Counter = `TIMEOUT`-1: set `fault`=11 and go to DONE.
  - Otherwise: increment the counter.
- **WR**: same as RD, using `wrdy`. Counter restarts at 0 on entry. `exc` gives `fault`=10. `cpu_rdata` is unchanged.
- **DONE**: `done`=1 for exactly one cycle, then go to IDLE.
- **Stale `exc`**: `exc` is ignored in the first cycle of each phase (counter=0), because that value comes from the previous access.
- **Dropping the strobe**: `read`/`write` deassert in the cycle after `rrdy`/`wrdy` is seen. The RAM therefore never sees a second request for the same access.
- **Requests while `busy`=1** are ignored and not queued. The CPU holds the request until it is accepted in IDLE.
- **Reset**: all state and outputs go to 0 (IDLE, strobes low, addresses, data and `fault` 0).
  - Reset mid-operation aborts the access.
  - A RAM write already sampled before the reset edge still completes in the RAM; this is accepted.

## Timing
- Request present in cycle 0 is accepted at the end of cycle 0.
- Read:
  - `read`=1 in cycles 1–2; `rrdy`=1 in cycle 2.
  - `done`, `cpu_rdata` valid in cycle 3; IDLE in cycle 4.
- Write: `write`=1 in cycles 1–2; `wrdy` in cycle 2; `done` in cycle 3.
- Swap: RD in cycles 1–2, WR in cycles 3–4, `done` in cycle 5.
- Out-of-range access (no macro): RAM raises `exc` in cycle 2; `done` with fault in cycle 3.
- Timeout: `done` in cycle `TIMEOUT`+1 for a single phase.
- Minimum request-to-request spacing is 4 cycles for reads and writes.

## Configuration
- `ADDR_CHECK_EN` defined:
  - In IDLE, a request with `cpu_addr` ≥ `MEM_SIZE` is not issued to the RAM.
  - Go directly to DONE with `fault`=01 for a read or swap, and 10 for a write.
  - `done` comes in cycle 1; `read`/`write` never assert.
- `ADDR_CHECK_EN` undefined: every request is issued, and out-of-range accesses are detected only through `exc`.

## Test plan
- Write 0xDEADBEEF to address 5, then read address 5 -> `done` in cycle 3 each time, `cpu_rdata`=0xDEADBEEF, `fault`=00, `read`/`write` each high exactly 2 cycles.
- Swap at address 7 (holding 0x11) with `cpu_wdata`=0x22 -> `cpu_rdata`=0x11, `done` in cycle 5, a later read of 7 returns 0x22.
- Read address 2000 (macro off) -> `fault`=01 in cycle 3. Then read address 5 -> `fault`=00; stale `exc` is ignored in cycle 1.
- RAM model that never asserts `rrdy` (`TIMEOUT`=16) -> `fault`=11, `done` in cycle 17, `read` low from cycle 17.
- `rst` asserted in cycle 2 of a read -> all outputs 0 in the next cycle and no `done`. A request issued afterwards completes normally.
- `ADDR_CHECK_EN` on, write address 1024 -> `done` in cycle 1, `fault`=10, `write` never high.

Source files
------------

// File: rtl/mem_access_unit.sv
// Request/ready initiator between the CPU32 execute stage and the single-port word RAM.
// Define ADDR_CHECK_EN to reject requests with cpu_addr >= MEM_SIZE before they reach the RAM.
module mem_access_unit #(
   parameter int unsigned TIMEOUT  = 16,
   parameter int unsigned MEM_SIZE = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   output logic        busy,
   output logic        done,
   output logic [31:0] cpu_rdata,
   output logic [1:0]  fault,
   output logic [31:0] r_addr,
   output logic [31:0] w_addr,
   output logic [31:0] w_line,
   input  logic [31:0] r_line,
   output logic        read,
   output logic        write,
   input  logic        rrdy,
   input  logic        wrdy,
   input  logic        exc
);

   localparam int unsigned CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   localparam logic [1:0] F_OK      = 2'b00;
   localparam logic [1:0] F_RD_EXC  = 2'b01;
   localparam logic [1:0] F_WR_EXC  = 2'b10;
   localparam logic [1:0] F_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t        state;
   logic          swap;
   logic [CW-1:0] cnt;
   logic          oob;

`ifdef ADDR_CHECK_EN
   assign oob = (cpu_addr >= MEM_SIZE);
`else
   logic unused_mem_size;
   assign oob             = 1'b0;
   assign unused_mem_size = ^MEM_SIZE;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         swap      <= 1'b0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cpu_rdata <= '0;
         fault     <= F_OK;
         r_addr    <= '0;
         w_addr    <= '0;
         w_line    <= '0;
         read      <= 1'b0;
         write     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_rd | cpu_wr) begin
                  r_addr <= cpu_addr;
                  w_addr <= cpu_addr;
                  w_line <= cpu_wdata;
                  swap   <= cpu_rd & cpu_wr;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  fault  <= F_OK;
                  if (oob) begin
                     state <= DONE;
                     done  <= 1'b1;
                     fault <= cpu_rd ? F_RD_EXC : F_WR_EXC;
                  end else if (cpu_rd) begin
                     state <= RD;
                     read  <= 1'b1;
                  end else begin
                     state <= WR;
                     write <= 1'b1;
                  end
               end
            end
            RD: begin
               // exc at cnt==0 is left over from the previous access and is ignored
               if (rrdy) begin
                  cpu_rdata <= r_line;
                  read      <= 1'b0;
                  cnt       <= '0;
                  if (swap) begin
                     state <= WR;
                     write <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                     fault <= F_OK;
                  end
               end else if (exc && cnt != '0) begin
                  read  <= 1'b0;
                  state <= DONE;
                  done  <= 1'b1;
                  fault <= F_RD_EXC;
               end else if (cnt == LAST) begin
                  read  <= 1'b0;
                  state <= DONE;
                  done  <= 1'b1;
                  fault <= F_TIMEOUT;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WR: begin
               if (wrdy) begin
                  write <= 1'b0;
                  state <= DONE;
                  done  <= 1'b1;
                  fault <= F_OK;
               end else if (exc && cnt != '0) begin
                  write <= 1'b0;
                  state <= DONE;
                  done  <= 1'b1;
                  fault <= F_WR_EXC;
               end else if (cnt == LAST) begin
                  write <= 1'b0;
                  state <= DONE;
                  done  <= 1'b1;
                  fault <= F_TIMEOUT;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
